stmt_stream_packer: RTL and testbench
=====================================

# stmt_stream_packer

Streaming nibble-to-byte packer with a valid/ready handshake on both sides. It is the packing counterpart of a streaming unpack `{>>{hi, lo}} = data`: the first accepted nibble lands in the upper half of the output word, and the second lands in the lower half. It sits between a nibble-wide producer and a byte-wide consumer, buffers completed words in a small output FIFO, and flags frame ends and zero-padded partial words.

## Interface

- `W`, default 4: input nibble width; output word is `2*W`.
- `DEPTH`, default 2: output FIFO entries; must be ≥1.
- `CNT_W`, default 16: width of the emitted-word counter.

Ports:

- `clk`, in, 1: single clock; all state updates on rising edge.
- `rst`, in, 1: reset; synchronous, active-high.
- `in_valid`, in, 1: producer has a nibble.
- `in_ready`, out, 1: packer accepts the nibble this cycle.
- `in_data`, in, `W`: nibble.
- `in_last`, in, 1: nibble ends the frame.
- `out_valid`, out, 1: FIFO head is valid.
- `out_ready`, in, 1: consumer takes the head this cycle.
- `out_data`, out, `2*W`: packed word, `{first, second}`.
- `out_last`, out, 1: word ends a frame.
- `out_pad`, out, 1: lower half is zero padding (odd-length frame).
- `word_count`, out, `CNT_W`: words handed off since reset.

## Operation

- Input handshake fires on `in_valid & in_ready`. Output handshake fires on `out_valid & out_ready`.
- Pack FSM, two states:
  - `EMPTY`, no nibble held.
    - Non-last nibble: store it in `hold`, go to `HALF`.
    - Last nibble: push `{in_data, 0}` with `last=1`, `pad=1`, stay in `EMPTY`.
  - `HALF`, `hold` valid.
    - Any nibble: push `{hold, in_data}` with `last=in_last`, `pad=0`, go to `EMPTY`.
- `in_ready = !rst & (fifo_count != DEPTH)`.
  - Registered-state only; no dependence on `in_valid`, `in_last` or `out_ready`.
  - Full FIFO blocks all input, including `EMPTY`→`HALF` loads.
- `out_valid = (fifo_count != 0)`. `out_data`, `out_last` and `out_pad` show the FIFO head and hold steady while `out_valid & !out_ready`.
- FIFO order is strict first-in first-out.
- Push and pop in the same cycle: both occur and `fifo_count` is unchanged. A push is never attempted when full, because `in_ready=0`.
- `word_count` increments by 1 on each output handshake and wraps modulo `2^CNT_W`.
- `out_data` bits outside a valid head are don't-care. The bench checks them only when `out_valid=1`.

## Timing

- Reset, effective at the edge where `rst=1`:
  - State goes to `EMPTY`, `hold` is cleared, `fifo_count=0`, `word_count=0`.
  - Outputs: `out_valid=0`, `out_data=0`, `out_last=0`, `out_pad=0`. `in_ready=0` while `rst` is high.
- Reset mid-operation discards the held nibble and all FIFO contents, with no partial flush. `in_ready` returns to 1 in the first cycle after `rst` falls.
- Latency: a word is visible on `out_valid` the cycle after the input handshake that completes it. There is no combinational path from input to output.
- Throughput: with `out_ready=1` held, one nibble is accepted per cycle and one word is emitted per two nibbles. `in_ready` stays 1.
- `DEPTH=1`: `in_ready` drops for the cycle after any push until that word is popped. The output side runs at reduced rate, which is acceptable.
- Back-to-back frames: `in_last` in `HALF` returns to `EMPTY`, and the next cycle may start a new frame with no bubble.

## Structure

- Package `stmt_stream_pkg`:
  - `pack_state_e` (`EMPTY`, `HALF`).
  - Packed struct `stream_word_t` with fields `data[2*W-1:0]`, `last`, `pad`, built for `W=4`.
  - Constant `STREAM_W_DEFAULT=4`.
- Sub-module `stmt_stream_fifo`:
  - Parameterized `DEPTH` × `(2*W+2)` synchronous FIFO.
  - Ports: `push`, `pop`, `full`, `empty`, `count`.
  - Read and write pointers wrap modulo `DEPTH`, which need not be a power of two.
  - Synchronous active-high reset.
- The top level holds the FSM, `hold`, handshake logic and `word_count`.

## Test plan

1. Even frame, `out_ready=1`: send `0xA`, then `0xB` with `in_last=1`.
   - Required: next cycle shows `out_valid=1`, `out_data=0xAB`, `out_last=1`, `out_pad=0`.
   - After that cycle, `word_count=1`.
2. Odd frame: send single nibble `0x5` with `in_last=1`.
   - Required: `out_data=0x50`, `out_last=1`, `out_pad=1`, and the FSM stays in `EMPTY`.
3. Backpressure, `DEPTH=2`, `out_ready=0`: offer nibbles `1` through `6`, with last on `6`.
   - Required: `in_ready` falls after nibble `4` and nibble `5` stalls.
   - Then raise `out_ready`. Required: words `0x12`, `0x34`, `0x56` in order, only `0x56` with `out_last=1`, then `word_count=3`.
4. Reset mid-word: load `0x7` (state `HALF`) and pulse `rst` for one cycle, then send `0x1`, then `0x2` with last.
   - Required: the only word is `0x12`, and `word_count` went to 0 at reset.
5. Streaming: `out_ready=1`, 20 nibbles `0..F,0..3`, last on the final nibble.
   - Required: `in_ready` is never 0, 10 words arrive with consistent pairing (`0x01`, `0x23`, …, `0x23`), and the cadence is one word per 2 cycles.
6. Counter wrap, `CNT_W=4`: 16 two-nibble frames.
   - Required: `word_count` reads 15 after 15 words and 0 after the 16th.

Source files
------------

// File: rtl/stmt_stream_pkg.sv
// Shared types and constants for the nibble-to-byte stream packer.
package stmt_stream_pkg;

  localparam int unsigned STREAM_W_DEFAULT = 4;

  typedef enum logic [0:0] {
    StEmpty,
    StHalf
  } pack_state_e;

  typedef struct packed {
    logic [2*STREAM_W_DEFAULT-1:0] data;
    logic                          last;
    logic                          pad;
  } stream_word_t;

endpackage

// File: rtl/stmt_stream_fifo.sv
// Synchronous FIFO for packed output words; depth need not be a power of two.
module stmt_stream_fifo #(
  parameter int unsigned Width = 10,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CntW  = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CntW-1:0]  count_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PtrW-1:0] LastIdx = PtrW'(DEPTH - 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);

  logic [Width-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == FullCnt);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = (wr_ptr_q == LastIdx) ? '0 : wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == LastIdx) ? '0 : rd_ptr_q + 1'b1;
    end
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; the top masks the head while the FIFO is empty.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/stmt_stream_packer.sv
// Packs pairs of nibbles into bytes (first nibble high), flags frame ends and
// zero-padded odd tails, and counts words handed to the consumer.
module stmt_stream_packer
  import stmt_stream_pkg::*;
#(
  parameter int unsigned W     = STREAM_W_DEFAULT,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [W-1:0]     in_data_i,
  input  logic             in_last_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [2*W-1:0]   out_data_o,
  output logic             out_last_o,
  output logic             out_pad_o,
  output logic [CNT_W-1:0] word_count_o
);

  localparam int unsigned WordW    = 2 * W + 2;
  localparam int unsigned FifoCntW = $clog2(DEPTH + 1);

  pack_state_e      state_q, state_d;
  logic [W-1:0]     hold_q, hold_d;
  logic [CNT_W-1:0] word_count_q, word_count_d;

  logic                in_fire, out_fire, push;
  logic [WordW-1:0]    push_word, head_word;
  logic                fifo_full, fifo_empty;
  logic [FifoCntW-1:0] fifo_count;

  assign in_ready_o  = ~rst_i & ~fifo_full;
  assign in_fire     = in_valid_i & in_ready_o;
  assign out_valid_o = ~fifo_empty;
  assign out_fire    = out_valid_o & out_ready_i;

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    push      = 1'b0;
    push_word = '0;
    if (in_fire) begin
      unique case (state_q)
        StEmpty: begin
          if (in_last_i) begin
            // Odd-length frame: lone nibble goes high, low half is padding.
            push      = 1'b1;
            push_word = {in_data_i, {W{1'b0}}, 1'b1, 1'b1};
          end else begin
            hold_d  = in_data_i;
            state_d = StHalf;
          end
        end
        StHalf: begin
          push      = 1'b1;
          push_word = {hold_q, in_data_i, in_last_i, 1'b0};
          state_d   = StEmpty;
        end
      endcase
    end
  end

  assign word_count_d = word_count_q + CNT_W'(out_fire);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StEmpty;
      hold_q       <= '0;
      word_count_q <= '0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      word_count_q <= word_count_d;
    end
  end

  stmt_stream_fifo #(
    .Width (WordW),
    .DEPTH (DEPTH),
    .CntW  (FifoCntW)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .wdata_i (push_word),
    .pop_i   (out_fire),
    .rdata_o (head_word),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assert property (@(posedge clk_i) fifo_empty == (fifo_count == '0));

  assign out_data_o   = out_valid_o ? head_word[WordW-1:2] : '0;
  assign out_last_o   = out_valid_o & head_word[1];
  assign out_pad_o    = out_valid_o & head_word[0];
  assign word_count_o = word_count_q;

endmodule

// File: tb/tb_stmt_stream_packer.sv
// Randomized and directed checks of the stream packer against a frame-level model.
module tb_stmt_stream_packer;

  localparam int unsigned W     = 4;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [W-1:0]     in_data = '0;
  logic             in_last = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [2*W-1:0]   out_data;
  logic             out_last;
  logic             out_pad;
  logic [CNT_W-1:0] word_count;

  always #5 clk = ~clk;

  stmt_stream_packer #(
    .W     (W),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .in_data_i    (in_data),
    .in_last_i    (in_last),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .out_data_o   (out_data),
    .out_last_o   (out_last),
    .out_pad_o    (out_pad),
    .word_count_o (word_count)
  );

  // Model: words completed but not yet consumed, as {byte, last, pad}.
  logic [9:0] exp_q[$];
  logic [3:0] frame_nib;
  bit         frame_odd;
  int         exp_wc;

  logic [9:0] popped_q[$];
  int         pop_cyc_q[$];
  int         cyc;
  int         n_cmp, n_err;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    frame_odd = 1'b0;
    frame_nib = '0;
    exp_wc    = 0;
  endtask

  // Nibbles of a frame pair up in arrival order; a frame ending on its
  // odd nibble yields that nibble high, zero low.
  task automatic model_accept(input logic [3:0] d, input logic l);
    if (frame_odd) begin
      exp_q.push_back({frame_nib, d, l, 1'b0});
      frame_odd = 1'b0;
    end else if (l) begin
      exp_q.push_back({d, 4'h0, 1'b1, 1'b1});
    end else begin
      frame_nib = d;
      frame_odd = 1'b1;
    end
  endtask

  // Called at a negedge; drives inputs, checks, advances one clock, returns at negedge.
  task automatic cycle(input logic v, input logic [3:0] d, input logic l, input logic ordy,
                       output logic acc);
    logic mready, mvalid, ofire;
    in_valid  = v;
    in_data   = d;
    in_last   = l;
    out_ready = ordy;
    #1;
    mready = !rst && (exp_q.size() < DEPTH);
    mvalid = (exp_q.size() != 0);
    check_value("in_ready", in_ready, mready);
    check_value("out_valid", out_valid, mvalid);
    if (mvalid) begin
      check_value("out_data", out_data, exp_q[0][9:2]);
      check_value("out_last", out_last, exp_q[0][1]);
      check_value("out_pad", out_pad, exp_q[0][0]);
    end
    check_value("word_count", word_count, exp_wc);
    if (out_valid && ordy) begin
      popped_q.push_back({out_data, out_last, out_pad});
      pop_cyc_q.push_back(cyc);
    end
    acc   = v && mready;
    ofire = mvalid && ordy;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      if (ofire) begin
        void'(exp_q.pop_front());
        exp_wc = (exp_wc + 1) % (1 << CNT_W);
      end
      if (acc) model_accept(d, l);
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic send(input logic [3:0] d, input logic l, input logic ordy, output int tries);
    logic acc;
    acc   = 1'b0;
    tries = 0;
    while (!acc && tries < 64) begin
      cycle(1'b1, d, l, ordy, acc);
      tries++;
    end
    check_value("send_accepted", acc, 1);
  endtask

  task automatic drain(input int n);
    logic acc;
    repeat (n) cycle(1'b0, 4'h0, 1'b0, 1'b1, acc);
  endtask

  task automatic do_reset();
    logic acc;
    rst = 1'b1;
    cycle(1'b0, 4'h0, 1'b0, 1'b0, acc);
    rst = 1'b0;
    #1;
    check_value("rst_out_valid", out_valid, 0);
    check_value("rst_out_data", out_data, 0);
    check_value("rst_out_last", out_last, 0);
    check_value("rst_out_pad", out_pad, 0);
    check_value("rst_word_count", word_count, 0);
    check_value("rst_in_ready_back", in_ready, 1);
    popped_q.delete();
    pop_cyc_q.delete();
  endtask

  initial begin
    int   tries, stalls;
    logic acc;
    n_cmp = 0;
    n_err = 0;
    cyc   = 0;
    model_reset();
    @(negedge clk);
    do_reset();

    // Even frame.
    send(4'hA, 1'b0, 1'b1, tries);
    send(4'hB, 1'b1, 1'b1, tries);
    check_value("t1_valid", out_valid, 1);
    check_value("t1_data", out_data, 8'hAB);
    check_value("t1_last", out_last, 1);
    check_value("t1_pad", out_pad, 0);
    drain(1);
    check_value("t1_count", word_count, 1);

    // Odd frames, back to back: FSM must stay empty.
    do_reset();
    send(4'h5, 1'b1, 1'b1, tries);
    check_value("t2_data", out_data, 8'h50);
    check_value("t2_last", out_last, 1);
    check_value("t2_pad", out_pad, 1);
    send(4'h9, 1'b1, 1'b1, tries);
    check_value("t2_data2", out_data, 8'h90);
    check_value("t2_pad2", out_pad, 1);
    drain(2);

    // Backpressure.
    do_reset();
    for (int i = 1; i <= 4; i++) send(4'(i), 1'b0, 1'b0, tries);
    check_value("t3_ready_low", in_ready, 0);
    cycle(1'b1, 4'h5, 1'b0, 1'b0, acc);
    cycle(1'b1, 4'h5, 1'b0, 1'b0, acc);
    send(4'h5, 1'b0, 1'b1, tries);
    send(4'h6, 1'b1, 1'b1, tries);
    drain(4);
    check_value("t3_n_words", popped_q.size(), 3);
    if (popped_q.size() == 3) begin
      check_value("t3_w0", popped_q[0], {8'h12, 2'b00});
      check_value("t3_w1", popped_q[1], {8'h34, 2'b00});
      check_value("t3_w2", popped_q[2], {8'h56, 2'b10});
    end
    check_value("t3_count", word_count, 3);

    // Reset mid-word discards the held nibble.
    do_reset();
    send(4'h7, 1'b0, 1'b1, tries);
    do_reset();
    send(4'h1, 1'b0, 1'b1, tries);
    send(4'h2, 1'b1, 1'b1, tries);
    drain(3);
    check_value("t4_n_words", popped_q.size(), 1);
    if (popped_q.size() == 1) check_value("t4_w0", popped_q[0], {8'h12, 2'b10});
    check_value("t4_count", word_count, 1);

    // Streaming throughput and cadence.
    do_reset();
    stalls = 0;
    for (int i = 0; i < 20; i++) begin
      send(4'(i % 16), (i == 19), 1'b1, tries);
      if (tries != 1) stalls++;
    end
    drain(3);
    check_value("t5_stalls", stalls, 0);
    check_value("t5_n_words", popped_q.size(), 10);
    for (int i = 0; i < popped_q.size(); i++) begin
      check_value("t5_word", popped_q[i][9:2], {4'((2 * i) % 16), 4'((2 * i + 1) % 16)});
      check_value("t5_flags", popped_q[i][1:0], {(i == 9), 1'b0});
      if (i > 0) check_value("t5_cadence", pop_cyc_q[i] - pop_cyc_q[i-1], 2);
    end

    // Counter wrap.
    do_reset();
    for (int i = 0; i < 15; i++) begin
      send(4'($urandom), 1'b0, 1'b1, tries);
      send(4'($urandom), 1'b1, 1'b1, tries);
    end
    drain(3);
    check_value("t6_count15", word_count, 15);
    send(4'h3, 1'b0, 1'b1, tries);
    send(4'h4, 1'b1, 1'b1, tries);
    drain(3);
    check_value("t6_wrap", word_count, 0);

    // Random traffic with occasional resets.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(299) == 0) begin
        do_reset();
      end else begin
        cycle(($urandom_range(3) != 0), 4'($urandom), ($urandom_range(3) == 0),
              ($urandom_range(4) < 3), acc);
      end
    end
    drain(6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
